ram_prog_loader: RTL and testbench



---
 rtl/picorv32_pkg.sv | 33 +++
 rtl/ram_prog_loader_uart_rx.sv | 114 +++++++++++
 rtl/ram_prog_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_ram_prog_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : picorv32_pkg
//  Description : Shared definitions for the serial program loader: the frame
//                sync byte, the loader state encoding and a helper that says
//                which states keep the SoC in reset.
//  Ports       : none (package)
//  Options     : PROG_CHECKSUM_EN (consumed by ram_prog_loader)
//  Revision    : 1.0 - initial release
// ============================================================================
package picorv32_pkg;

    localparam logic [7:0] PROG_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        PROG_IDLE  = 3'd0,
        PROG_LEN0  = 3'd1,
        PROG_LEN1  = 3'd2,
        PROG_DATA  = 3'd3,
        PROG_CSUM  = 3'd4,
        PROG_DONE  = 3'd5,
        PROG_ERROR = 3'd6
    } prog_state_e;

    // States in which a frame is being consumed or the image is known bad;
    // the CPU must stay in reset and the programming LED is lit.
    function automatic logic prog_holds_soc(input prog_state_e s);
        return (s == PROG_LEN0) || (s == PROG_LEN1) || (s == PROG_DATA) ||
               (s == PROG_CSUM) || (s == PROG_ERROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_prog_loader_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : prog_uart_rx
//  Description : 8N1 UART receiver for the program loader. Synchronizes the
//                line, finds the falling start edge, samples each bit at its
//                middle and reports either a good byte or a framing error.
//  Ports       : clk_i       - system clock
//                rst_ni      - synchronous active-low reset
//                rx_i        - asynchronous serial line, idles high
//                rx_byte_o   - last received byte
//                rx_valid_o  - one-cycle pulse, byte good (stop bit = 1)
//                rx_ferr_o   - one-cycle pulse, stop bit sampled as 0
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       rx_ferr_o
);

    localparam int                 c_cnt_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_m1 = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [1:0]         r_sync_q,  w_sync_d;
    logic               r_prev_q,  w_prev_d;
    logic               r_busy_q,  w_busy_d;
    logic [c_cnt_w-1:0] r_cnt_q,   w_cnt_d;
    logic [3:0]         r_bit_q,   w_bit_d;    // 0 start, 1..8 data, 9 stop
    logic [7:0]         r_shift_q, w_shift_d;
    logic [7:0]         r_byte_q,  w_byte_d;
    logic               r_valid_q, w_valid_d;
    logic               r_ferr_q,  w_ferr_d;
    logic               w_line;

    always_comb begin
        w_line    = r_sync_q[1];
        w_sync_d  = {r_sync_q[0], rx_i};
        w_prev_d  = w_line;
        w_busy_d  = r_busy_q;
        w_cnt_d   = r_cnt_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_byte_d  = r_byte_q;
        w_valid_d = 1'b0;
        w_ferr_d  = 1'b0;

        if (!r_busy_q) begin
            if (r_prev_q && !w_line) begin
                w_busy_d = 1'b1;
                w_cnt_d  = c_half_m1;
                w_bit_d  = 4'd0;
            end
        end else if (r_cnt_q != '0) begin
            w_cnt_d = r_cnt_q - 1'b1;
        end else begin
            w_cnt_d = c_full_m1;
            if (r_bit_q == 4'd0) begin
                // A start bit that is high again at mid-bit was a glitch.
                if (w_line) begin
                    w_busy_d = 1'b0;
                end else begin
                    w_bit_d = 4'd1;
                end
            end else if (r_bit_q <= 4'd8) begin
                w_shift_d = {w_line, r_shift_q[7:1]};
                w_bit_d   = r_bit_q + 4'd1;
            end else begin
                w_busy_d = 1'b0;
                if (w_line) begin
                    w_valid_d = 1'b1;
                    w_byte_d  = r_shift_q;
                end else begin
                    w_ferr_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync_q  <= 2'b11;
            r_prev_q  <= 1'b1;
            r_busy_q  <= 1'b0;
            r_cnt_q   <= '0;
            r_bit_q   <= 4'd0;
            r_shift_q <= 8'h00;
            r_byte_q  <= 8'h00;
            r_valid_q <= 1'b0;
            r_ferr_q  <= 1'b0;
        end else begin
            r_sync_q  <= w_sync_d;
            r_prev_q  <= w_prev_d;
            r_busy_q  <= w_busy_d;
            r_cnt_q   <= w_cnt_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_byte_q  <= w_byte_d;
            r_valid_q <= w_valid_d;
            r_ferr_q  <= w_ferr_d;
        end
    end

    assign rx_byte_o  = r_byte_q;
    assign rx_valid_o = r_valid_q;
    assign rx_ferr_o  = r_ferr_q;

endmodule
`default_nettype wire

// File: rtl/ram_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_prog_loader
//  Description : Serial boot loader. Receives a framed program image
//                (A5, N[15:0] LSB first, N little-endian words, optional
//                checksum) and writes it into SRAM, holding the SoC in reset
//                while the frame is in progress or after a failed load.
//  Ports       : clk_i           - system clock
//                rst_ni          - board-level synchronous active-low reset
//                prog_rx_i       - asynchronous UART line (8N1, idles high)
//                mem_we_o        - one-cycle SRAM write strobe
//                mem_addr_o      - SRAM word address
//                mem_wdata_o     - SRAM write data
//                system_reset_o  - active-low SoC reset request
//                prog_mode_led_o - frame in progress or error
//                err_o           - sticky error flag
//  Options     : PROG_CHECKSUM_EN - adds the trailing modulo-256 checksum
//                byte over the data bytes and the CSUM state.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_prog_loader
    import picorv32_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int RAM_DEPTH    = 4096,
    parameter int ADDR_W       = $clog2(RAM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              prog_rx_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              system_reset_o,
    output logic              prog_mode_led_o,
    output logic              err_o
);

    localparam logic [16:0] c_depth = 17'(RAM_DEPTH);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_ferr;

    prog_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_i       (prog_rx_i),
        .rx_byte_o  (w_rx_byte),
        .rx_valid_o (w_rx_valid),
        .rx_ferr_o  (w_rx_ferr)
    );

    prog_state_e       r_state_q,    w_state_d;
    logic [15:0]       r_len_q,      w_len_d;
    logic [15:0]       r_word_idx_q, w_word_idx_d;
    logic [1:0]        r_byte_idx_q, w_byte_idx_d;
    logic [23:0]       r_asm_q,      w_asm_d;     // first three bytes of a word
    logic              r_ovf_q,      w_ovf_d;     // a word fell beyond RAM_DEPTH
    logic              r_err_q,      w_err_d;
    logic              r_we_q,       w_we_d;
    logic [ADDR_W-1:0] r_addr_q,     w_addr_d;
    logic [31:0]       r_wdata_q,    w_wdata_d;
    logic              r_sysrst_q,   w_sysrst_d;
    logic              r_led_q,      w_led_d;
    logic [31:0]       w_word;
`ifdef PROG_CHECKSUM_EN
    logic [7:0]        r_sum_q,      w_sum_d;
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_len_d      = r_len_q;
        w_word_idx_d = r_word_idx_q;
        w_byte_idx_d = r_byte_idx_q;
        w_asm_d      = r_asm_q;
        w_ovf_d      = r_ovf_q;
        w_err_d      = r_err_q;
        w_we_d       = 1'b0;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
`ifdef PROG_CHECKSUM_EN
        w_sum_d      = r_sum_q;
`endif
        // Words arrive LSB first, so each new byte lands on top.
        w_word       = {w_rx_byte, r_asm_q};

        case (r_state_q)
            PROG_IDLE, PROG_ERROR: begin
                if (w_rx_valid && (w_rx_byte == PROG_SYNC_BYTE)) begin
                    w_state_d    = PROG_LEN0;
                    w_err_d      = 1'b0;
                    w_ovf_d      = 1'b0;
                    w_word_idx_d = 16'd0;
                    w_byte_idx_d = 2'd0;
`ifdef PROG_CHECKSUM_EN
                    w_sum_d      = 8'h00;
`endif
                end
            end
            PROG_LEN0: begin
                if (w_rx_valid) begin
                    w_len_d[7:0] = w_rx_byte;
                    w_state_d    = PROG_LEN1;
                end
            end
            PROG_LEN1: begin
                if (w_rx_valid) begin
                    w_len_d[15:8] = w_rx_byte;
                    if ({w_rx_byte, r_len_q[7:0]} != 16'd0) begin
                        w_state_d = PROG_DATA;
                    end else begin
`ifdef PROG_CHECKSUM_EN
                        w_state_d = PROG_CSUM;
`else
                        w_state_d = PROG_DONE;
`endif
                    end
                end
            end
            PROG_DATA: begin
                if (w_rx_valid) begin
`ifdef PROG_CHECKSUM_EN
                    w_sum_d      = r_sum_q + w_rx_byte;
`endif
                    w_asm_d      = w_word[31:8];
                    w_byte_idx_d = r_byte_idx_q + 2'd1;
                    if (r_byte_idx_q == 2'd3) begin
                        // Out-of-range words are consumed but never written;
                        // the address stays at its last legal value.
                        if ({1'b0, r_word_idx_q} < c_depth) begin
                            w_we_d    = 1'b1;
                            w_addr_d  = r_word_idx_q[ADDR_W-1:0];
                            w_wdata_d = w_word;
                        end else begin
                            w_ovf_d = 1'b1;
                            w_err_d = 1'b1;
                        end
                        w_word_idx_d = r_word_idx_q + 16'd1;
                        if (w_word_idx_d == r_len_q) begin
`ifdef PROG_CHECKSUM_EN
                            w_state_d = PROG_CSUM;
`else
                            w_state_d = w_ovf_d ? PROG_ERROR : PROG_DONE;
`endif
                        end
                    end
                end
            end
`ifdef PROG_CHECKSUM_EN
            PROG_CSUM: begin
                if (w_rx_valid) begin
                    if ((w_rx_byte == r_sum_q) && !r_ovf_q) begin
                        w_state_d = PROG_DONE;
                    end else begin
                        w_state_d = PROG_ERROR;
                        w_err_d   = 1'b1;
                    end
                end
            end
`endif
            PROG_DONE: begin
                w_state_d = PROG_IDLE;
            end
            default: begin
                w_state_d = PROG_IDLE;
            end
        endcase

        // A broken byte anywhere inside a frame invalidates the image; in
        // IDLE it is just line noise.
        if (w_rx_ferr && (r_state_q != PROG_IDLE)) begin
            w_state_d = PROG_ERROR;
            w_err_d   = 1'b1;
            w_we_d    = 1'b0;
        end

        w_sysrst_d = !prog_holds_soc(w_state_d);
        w_led_d    = prog_holds_soc(w_state_d);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_q    <= PROG_IDLE;
            r_len_q      <= 16'd0;
            r_word_idx_q <= 16'd0;
            r_byte_idx_q <= 2'd0;
            r_asm_q      <= 24'd0;
            r_ovf_q      <= 1'b0;
            r_err_q      <= 1'b0;
            r_we_q       <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= 32'd0;
            r_sysrst_q   <= 1'b1;
            r_led_q      <= 1'b0;
`ifdef PROG_CHECKSUM_EN
            r_sum_q      <= 8'h00;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_len_q      <= w_len_d;
            r_word_idx_q <= w_word_idx_d;
            r_byte_idx_q <= w_byte_idx_d;
            r_asm_q      <= w_asm_d;
            r_ovf_q      <= w_ovf_d;
            r_err_q      <= w_err_d;
            r_we_q       <= w_we_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_sysrst_q   <= w_sysrst_d;
            r_led_q      <= w_led_d;
`ifdef PROG_CHECKSUM_EN
            r_sum_q      <= w_sum_d;
`endif
        end
    end

    assign mem_we_o        = r_we_q;
    assign mem_addr_o      = r_addr_q;
    assign mem_wdata_o     = r_wdata_q;
    assign system_reset_o  = r_sysrst_q;
    assign prog_mode_led_o = r_led_q;
    assign err_o           = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_prog_loader
//  Description : Self-checking bench for ram_prog_loader. Builds frames from
//                random words, serializes them on the UART line and compares
//                the captured SRAM writes and status outputs with the values
//                implied by the frame contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_prog_loader;

    localparam int CPB   = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          rx     = 1'b1;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          sysrst;
    logic          led;
    logic          err;

    always #5 clk = ~clk;

    ram_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .RAM_DEPTH    (DEPTH),
        .ADDR_W       (AW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .prog_rx_i       (rx),
        .mem_we_o        (we),
        .mem_addr_o      (addr),
        .mem_wdata_o     (wdata),
        .system_reset_o  (sysrst),
        .prog_mode_led_o (led),
        .err_o           (err)
    );

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   got_addr[$];
    logic [31:0]   got_data[$];
    logic [31:0]   words[$];
    int            we_wide = 0;
    logic          we_prev = 1'b0;

    // Capture every write strobe; a strobe seen on two consecutive cycles
    // is recorded as a width violation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            got_addr.push_back(32'(addr));
            got_data.push_back(wdata);
            if (we_prev) we_wide <= we_wide + 1;
        end
        we_prev <= (we === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, stop bit, then one idle bit time.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
        idle(CPB);
    endtask

    function automatic logic [7:0] data_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++)
                s = s + int'((words[i] >> (8 * k)) & 32'hFF);
        return 8'(s % 256);
    endfunction

    task automatic send_frame(input int n, input int csum_delta);
        logic [15:0] len;
        logic [31:0] w;
        len = 16'(n);
        send_byte(8'hA5, 1'b1);
        check("rst_low_after_sync", 32'(sysrst), 32'd0);
        send_byte(len[7:0], 1'b1);
        send_byte(len[15:8], 1'b1);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
        end
`ifdef PROG_CHECKSUM_EN
        check("rst_low_before_csum", 32'(sysrst), 32'd0);
        send_byte(data_sum(n) + 8'(csum_delta), 1'b1);
`else
        if (csum_delta != 0) $display("note: checksum offset ignored, checksum not built");
`endif
        idle(4);
    endtask

    task automatic expect_writes(input int n);
        int m;
        m = (n < DEPTH) ? n : DEPTH;
        check("write_count", 32'(got_addr.size()), 32'(m));
        for (int i = 0; i < m && i < got_addr.size(); i++) begin
            check("write_addr", got_addr[i], 32'(i));
            check("write_data", got_data[i], words[i]);
        end
        check("we_one_cycle", 32'(we_wide), 32'd0);
    endtask

    task automatic expect_status(input logic exp_err);
        check("err", 32'(err), 32'(exp_err));
        check("system_reset", 32'(sysrst), 32'(!exp_err));
        check("led", 32'(led), 32'(exp_err));
    endtask

    task automatic new_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
        got_addr.delete();
        got_data.delete();
    endtask

    initial begin
        int n;

        // Reset values
        idle(3);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_sysrst", 32'(sysrst), 32'd1);
        check("rst_led", 32'(led), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Noise before the sync byte is ignored
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b1);
        check("noise_sysrst", 32'(sysrst), 32'd1);
        check("noise_led", 32'(led), 32'd0);
        check("noise_writes", 32'(got_addr.size()), 32'd0);

        // Directed two-word frame
        new_words(0);
        words.push_back(32'hDEADBEEF);
        words.push_back(32'h00000013);
        send_frame(2, 0);
        expect_writes(2);
        expect_status(1'b0);

`ifdef PROG_CHECKSUM_EN
        // Wrong checksum: data still written, load rejected
        got_addr.delete();
        got_data.delete();
        send_frame(2, 1);
        expect_writes(2);
        expect_status(1'b1);
        new_words(3);
        send_frame(3, 0);
        expect_writes(3);
        expect_status(1'b0);
`endif

        // Random frames
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 4);
            new_words(n);
            send_frame(n, 0);
            expect_writes(n);
            expect_status(1'b0);
        end

        // Empty frame
        new_words(0);
        send_frame(0, 0);
        expect_writes(0);
        expect_status(1'b0);

        // Framing error on the second data byte
        new_words(1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(words[0][7:0], 1'b1);
        send_byte(words[0][15:8], 1'b0);
        idle(4);
        check("ferr_writes", 32'(got_addr.size()), 32'd0);
        expect_status(1'b1);

        // Recovery from the error state
        new_words(2);
        send_frame(2, 0);
        expect_writes(2);
        expect_status(1'b0);

        // Board reset after six data bytes
        new_words(2);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(8'(words[0] >> (8 * k)), 1'b1);
        send_byte(words[1][7:0], 1'b1);
        send_byte(words[1][15:8], 1'b1);
        check("midrst_writes", 32'(got_addr.size()), 32'd1);
        check("midrst_addr", (got_addr.size() > 0) ? got_addr[0] : 32'hFFFFFFFF, 32'd0);
        check("midrst_data", (got_data.size() > 0) ? got_data[0] : ~words[0], words[0]);
        check("midrst_sysrst_before", 32'(sysrst), 32'd0);
        rst_n = 1'b0;
        idle(1);
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_addr_out", 32'(addr), 32'd0);
        check("midrst_wdata_out", wdata, 32'd0);
        check("midrst_sysrst", 32'(sysrst), 32'd1);
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        idle(4 * CPB);
        check("midrst_no_more_writes", 32'(got_addr.size()), 32'd1);
        check("midrst_sysrst_after", 32'(sysrst), 32'd1);

        // Address overflow: N = DEPTH + 1
        new_words(DEPTH + 1);
        send_frame(DEPTH + 1, 0);
        expect_writes(DEPTH + 1);
        check("ovf_last_addr", 32'(addr), 32'(DEPTH - 1));
        expect_status(1'b1);

        // A valid frame after overflow clears the error
        new_words(1);
        send_frame(1, 0);
        expect_writes(1);
        expect_status(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
